and_inv_tree_pipe: RTL and testbench

Parametrised, pipelined AND-tree regression block with per-group output inversion and valid/ready flow control. It generalises the fixed 8-input "AND of two 4-input groups, second group inverted" test circuit to N_IN inputs, a runtime inversion mask and configurable pipeline depth. It sits in the regression test set as a sequential reference circuit for synthesis and equivalence flows.

---
 rtl/and_inv_tree_pipe.sv | 95 +++++++++
 tb/tb_and_inv_tree_pipe.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/and_inv_tree_pipe.sv
// and_inv_tree_pipe: pipelined AND tree with per-group inversion mask and valid/ready flow control.
// Define AND_INV_TREE_HIT_CNT_EN to enable the saturating hit counter on hit_cnt.
module and_inv_tree_pipe #(
  parameter int N_IN = 8,
  parameter int GROUP = 4,
  parameter int STAGE_GAP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN-1:0]         pi,
  input  logic                    mask_we,
  input  logic [N_IN/GROUP-1:0]   mask_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    po,
  output logic [15:0]             hit_cnt
);
  localparam int NG = N_IN / GROUP;
  localparam int L = $clog2(N_IN);
  localparam int GL = $clog2(GROUP);
  logic [NG-1:0] inv_mask_q;
  logic [2*N_IN-2:0] t;
  logic [L:0] vl;
  logic [GL:0][NG-1:0] m_lv;
  assign in_ready = ~(out_valid & ~out_ready);
  always_ff @(posedge clk)
    if (rst) inv_mask_q <= '0;
    else if (mask_we) inv_mask_q <= mask_in;
  assign vl[0] = in_valid & in_ready;
  assign m_lv[0] = inv_mask_q;
  // t packs every tree level back to back: level l occupies N_IN>>l bits at offset 2*N_IN - 2*(N_IN>>l)
  genvar l, j;
  for (l = 0; l <= L; l++) begin : g_lv
    localparam int W = N_IN >> l;
    localparam int OFF = 2*N_IN - 2*W;
    localparam bit R = (l > 0) && ((l % STAGE_GAP == 0) || (l == L));
    logic [W-1:0] a, x_d;
    if (l == 0) begin : g_leaf
      assign a = pi;
    end else begin : g_and
      for (j = 0; j < W; j++) begin : g_b
        assign a[j] = t[OFF - 2*W + 2*j] & t[OFF - 2*W + 2*j + 1];
      end
    end
    if (l == GL) begin : g_inv
      assign x_d = a ^ m_lv[GL];
    end else begin : g_pass
      assign x_d = a;
    end
    if (R) begin : g_reg
      logic [W-1:0] x_q;
      logic v_q;
      always_ff @(posedge clk)
        if (rst) begin
          x_q <= '0;
          v_q <= 1'b0;
        end else if (in_ready) begin
          x_q <= x_d;
          v_q <= vl[l-1];
        end
      assign t[OFF +: W] = x_q;
      assign vl[l] = v_q;
    end else begin : g_comb
      assign t[OFF +: W] = x_d;
      if (l > 0) begin : g_v
        assign vl[l] = vl[l-1];
      end
    end
    // mask bits ride along with the beat until the inversion level consumes them
    if (l < GL) begin : g_m
      if (R) begin : g_mr
        logic [NG-1:0] m_q;
        always_ff @(posedge clk)
          if (rst) m_q <= '0;
          else if (in_ready) m_q <= m_lv[l];
        assign m_lv[l+1] = m_q;
      end else begin : g_mc
        assign m_lv[l+1] = m_lv[l];
      end
    end
  end
  assign out_valid = vl[L];
  assign po = t[2*N_IN-2];
`ifdef AND_INV_TREE_HIT_CNT_EN
  logic [15:0] hit_q;
  always_ff @(posedge clk)
    if (rst) hit_q <= '0;
    else if (out_valid & out_ready & po & ~&hit_q) hit_q <= hit_q + 16'd1;
  assign hit_cnt = hit_q;
`else
  assign hit_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_and_inv_tree_pipe.sv
// tb_and_inv_tree_pipe: directed checks of the default build and a 16-input, 2-leaf-group, gap-2 build.
module tb_and_inv_tree_pipe;
  logic clk = 1'b0;
  logic rst;
  logic a_iv, a_ir, a_mwe, a_ov, a_or, a_po;
  logic [7:0] a_pi;
  logic [1:0] a_mi;
  logic [15:0] a_hit;
  logic b_iv, b_ir, b_mwe, b_ov, b_or, b_po;
  logic [15:0] b_pi;
  logic [7:0] b_mi;
  logic [15:0] b_hit;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  and_inv_tree_pipe u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .pi(a_pi),
    .mask_we(a_mwe), .mask_in(a_mi), .out_valid(a_ov), .out_ready(a_or),
    .po(a_po), .hit_cnt(a_hit)
  );

  and_inv_tree_pipe #(.N_IN(16), .GROUP(2), .STAGE_GAP(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .pi(b_pi),
    .mask_we(b_mwe), .mask_in(b_mi), .out_valid(b_ov), .out_ready(b_or),
    .po(b_po), .hit_cnt(b_hit)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic p);
    chk({tag, "_ov"}, {15'd0, a_ov}, {15'd0, ov});
    if (ov) chk({tag, "_po"}, {15'd0, a_po}, {15'd0, p});
  endtask

  initial begin
    rst = 1'b1;
    a_iv = 0; a_pi = '0; a_mwe = 0; a_mi = '0; a_or = 1;
    b_iv = 0; b_pi = '0; b_mwe = 0; b_mi = '0; b_or = 1;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_ov", {15'd0, a_ov}, 16'd0);
    chk("rst_po", {15'd0, a_po}, 16'd0);
    chk("rst_ir", {15'd0, a_ir}, 16'd1);
    chk("rst_hit", a_hit, 16'd0);
    chk("rst_b_ov", {15'd0, b_ov}, 16'd0);
    chk("rst_b_ir", {15'd0, b_ir}, 16'd1);

    a_mwe = 1; a_mi = 2'b10;
    step();
    a_mwe = 0;
    a_iv = 1; a_pi = 8'h0F;
    step();
    chk_out("lat1", 0, 0);
    a_pi = 8'hFF;
    step();
    chk_out("lat2", 0, 0);
    a_pi = 8'h07;
    step();
    chk_out("f0F", 1, 1);
    a_iv = 0;
    step();
    chk_out("fFF", 1, 0);
    step();
    chk_out("f07", 1, 0);
    step();
    chk_out("fdrain", 0, 0);

    a_mwe = 1; a_mi = 2'b00;
    step();
    a_iv = 1; a_pi = 8'hFF; a_mwe = 1; a_mi = 2'b10;
    step();
    a_mwe = 0;
    step();
    a_iv = 0;
    step();
    chk_out("mold", 1, 1);
    step();
    chk_out("mnew", 1, 0);
    step();
    chk_out("mdrain", 0, 0);

    a_iv = 1; a_or = 1; a_pi = 8'h0F;
    step();
    a_pi = 8'hFF;
    step();
    a_pi = 8'h0F;
    step();
    chk_out("bp_b0", 1, 1);
    a_pi = 8'h0F; a_or = 0;
    #1 chk("bp_ir_comb", {15'd0, a_ir}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("bp_hold", 1, 1);
      chk("bp_ir", {15'd0, a_ir}, 16'd0);
    end
    a_or = 1;
    step();
    chk_out("bp_b1", 1, 0);
    a_pi = 8'h07;
    step();
    chk_out("bp_b2", 1, 1);
    a_pi = 8'h0F;
    step();
    chk_out("bp_b3", 1, 1);
    a_iv = 0;
    step();
    chk_out("bp_b4", 1, 0);
    step();
    chk_out("bp_b5", 1, 1);
    step();
    chk_out("bp_drain", 0, 0);

    a_iv = 1; a_pi = 8'h0F;
    repeat (3) step();
    chk_out("rs_full", 1, 1);
    a_iv = 0; rst = 1; a_mwe = 1; a_mi = 2'b01;
    step();
    rst = 0; a_mwe = 0;
    chk("rs_ov", {15'd0, a_ov}, 16'd0);
    chk("rs_po", {15'd0, a_po}, 16'd0);
    chk("rs_ir", {15'd0, a_ir}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rs_stale", {15'd0, a_ov}, 16'd0);
    end
    a_iv = 1; a_pi = 8'hFF;
    step();
    a_iv = 0;
    step();
    step();
    chk_out("rs_mask0", 1, 1);
    step();
    chk_out("rs_drain", 0, 0);

    b_mwe = 1; b_mi = 8'hFF;
    step();
    b_mwe = 0; b_iv = 1; b_pi = 16'h0000;
    step();
    chk("b_lat1", {15'd0, b_ov}, 16'd0);
    b_pi = 16'h0003;
    step();
    chk("b_ov0", {15'd0, b_ov}, 16'd1);
    chk("b_po0", {15'd0, b_po}, 16'd1);
    b_iv = 0;
    step();
    chk("b_ov1", {15'd0, b_ov}, 16'd1);
    chk("b_po1", {15'd0, b_po}, 16'd0);
    step();
    chk("b_drain", {15'd0, b_ov}, 16'd0);

    rst = 1;
    step();
    rst = 0;
    a_iv = 1;
    for (int i = 0; i < 8; i++) begin
      a_pi = (i == 1 || i == 3 || i == 5) ? 8'h00 : 8'hFF;
      step();
    end
    a_iv = 0;
    repeat (4) step();
`ifdef AND_INV_TREE_HIT_CNT_EN
    chk("hit5", a_hit, 16'd5);
    rst = 1;
    step();
    rst = 0;
    a_iv = 1; a_pi = 8'hFF;
    repeat (65537) step();
    a_iv = 0;
    repeat (4) step();
    chk("hit_sat", a_hit, 16'hFFFF);
`else
    chk("hit_off", a_hit, 16'd0);
    chk("hit_off_b", b_hit, 16'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
